// File: rtl/ysyx_25060170_mem_arbiter.sv
// Shares one data-memory port between the IFU (read-only) and the LSU (read/write).
// One transaction in flight at a time: accept -> issue -> wait -> deliver.
module ysyx_25060170_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int MAX_STREAK = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   input  logic                ifu_rsp_ready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic                ifu_rsp_err,

   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   output logic                lsu_rsp_valid,
   input  logic                lsu_rsp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_rsp_err,

   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_rsp_valid,
   output logic                mem_rsp_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_rsp_err,

   output logic                busy
);

   localparam int STRB_W = DATA_W / 8;
   localparam int SW     = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
   localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
   // The timeout fires in the cycle whose increment would bring the timer to TIMEOUT.
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_DELIVER = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;      // 1 = LSU owns the transaction
   logic [SW-1:0]       streak_q, streak_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic                drain_q, drain_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic gnt_lsu, gnt_ifu, accept, timer_hit, owner_rsp_ready;

   always_comb begin
      gnt_lsu = 1'b0;
      gnt_ifu = 1'b0;
      if (state_q == S_IDLE && !drain_q) begin
         gnt_lsu = lsu_req_valid && !(ifu_req_valid && streak_q == STREAK_MAX);
         gnt_ifu = !gnt_lsu && ifu_req_valid;
      end
   end

   assign accept          = gnt_lsu || gnt_ifu;
   assign timer_hit       = (timer_q == TIMER_LAST);
   assign owner_rsp_ready = owner_q ? lsu_rsp_ready : ifu_rsp_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (accept) state_d = S_ISSUE;
         S_ISSUE: begin
            if (mem_req_ready)  state_d = S_WAIT;
            else if (timer_hit) state_d = S_DELIVER;
         end
         S_WAIT:    if (mem_rsp_valid || timer_hit) state_d = S_DELIVER;
         S_DELIVER: if (owner_rsp_ready) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // NOTE: every variable gets a default before the case so no latches are inferred.
   always_comb begin
      owner_d  = owner_q;
      streak_d = streak_q;
      timer_d  = timer_q;
      drain_d  = drain_q;
      addr_d   = addr_q;
      wen_d    = wen_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      rdata_d  = rdata_q;
      err_d    = err_q;

      // A late response after a wait timeout is swallowed here; drain only lives in IDLE/DELIVER.
      if (drain_q && mem_rsp_valid) drain_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               owner_d = gnt_lsu;
               addr_d  = gnt_lsu ? lsu_addr : ifu_addr;
               wen_d   = gnt_lsu && lsu_wen;
               wdata_d = gnt_lsu ? lsu_wdata : '0;
               wstrb_d = gnt_lsu ? lsu_wstrb : '0;
               rdata_d = '0;
               err_d   = 1'b0;
               timer_d = '0;
            end
            if (gnt_ifu) begin
               streak_d = '0;
            end else if (gnt_lsu && ifu_req_valid && streak_q != STREAK_MAX) begin
               streak_d = streak_q + 1'b1;
            end
         end
         S_ISSUE: begin
            timer_d = timer_q + 1'b1;
            if (!mem_req_ready && timer_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         S_WAIT: begin
            timer_d = timer_q + 1'b1;
            if (mem_rsp_valid) begin
               rdata_d = mem_rdata;
               err_d   = mem_rsp_err;
            end else if (timer_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
               drain_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // NOTE: the latched request/response fields are reset too, since they drive outputs directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q  <= 1'b0;
         streak_q <= '0;
         timer_q  <= '0;
         drain_q  <= 1'b0;
         addr_q   <= '0;
         wen_q    <= 1'b0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         owner_q  <= owner_d;
         streak_q <= streak_d;
         timer_q  <= timer_d;
         drain_q  <= drain_d;
         addr_q   <= addr_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Outputs are forced low while rst is high, whatever state the registers still hold.
   always_comb begin
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
      ifu_rdata     = '0;
      lsu_rdata     = '0;
      ifu_rsp_err   = 1'b0;
      lsu_rsp_err   = 1'b0;
      mem_req_valid = 1'b0;
      mem_addr      = '0;
      mem_wen       = 1'b0;
      mem_wdata     = '0;
      mem_wstrb     = '0;
      mem_rsp_ready = 1'b0;
      busy          = 1'b0;
      if (!rst) begin
         ifu_req_ready = gnt_ifu;
         lsu_req_ready = gnt_lsu;
         mem_req_valid = (state_q == S_ISSUE);
         mem_addr      = addr_q;
         mem_wen       = wen_q;
         mem_wdata     = wdata_q;
         mem_wstrb     = wstrb_q;
         mem_rsp_ready = (state_q == S_WAIT) || drain_q;
         ifu_rsp_valid = (state_q == S_DELIVER) && !owner_q;
         lsu_rsp_valid = (state_q == S_DELIVER) && owner_q;
         if (owner_q) begin
            lsu_rdata   = rdata_q;
            lsu_rsp_err = err_q;
         end else begin
            ifu_rdata   = rdata_q;
            ifu_rsp_err = err_q;
         end
         busy = (state_q != S_IDLE) || drain_q;
      end
   end

endmodule

// File: tb/tb_ysyx_25060170_mem_arbiter.sv
// Directed bench for ysyx_25060170_mem_arbiter: a table of single transactions plus
// hand-written sequences for wait states, timeout/drain, held responses and reset.
module tb_ysyx_25060170_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
   logic [31:0] ifu_addr;
   logic [63:0] ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
   logic [31:0] lsu_addr;
   logic [63:0] lsu_wdata, lsu_rdata;
   logic [7:0]  lsu_wstrb;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata, mem_rdata;
   logic [7:0]  mem_wstrb;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ysyx_25060170_mem_arbiter #(
      .ADDR_W(32), .DATA_W(64), .MAX_STREAK(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
      .ifu_rsp_err(ifu_rsp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
      .lsu_rsp_err(lsu_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
      .mem_rsp_err(mem_rsp_err),
      .busy(busy)
   );

   typedef struct {
      logic        ifu_v, lsu_v, wen;
      logic [31:0] ia, la;
      logic [63:0] wd;
      logic [7:0]  ws;
      logic [63:0] rd;
      logic        er;
      logic        exp_lsu;
      logic [31:0] exp_addr;
      logic        exp_wen;
      logic [63:0] exp_wdata;
      logic [7:0]  exp_wstrb;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ifu_v, input logic lsu_v, input logic wen,
                               input logic [31:0] ia, input logic [31:0] la,
                               input logic [63:0] wd, input logic [7:0] ws,
                               input logic [63:0] rd, input logic er, input logic exp_lsu);
      vec_t v;
      v.ifu_v = ifu_v; v.lsu_v = lsu_v; v.wen = wen; v.ia = ia; v.la = la;
      v.wd = wd; v.ws = ws; v.rd = rd; v.er = er; v.exp_lsu = exp_lsu;
      // IFU transactions are always reads with an empty strobe.
      v.exp_addr  = exp_lsu ? la : ia;
      v.exp_wen   = exp_lsu & wen;
      v.exp_wdata = exp_lsu ? wd : 64'h0;
      v.exp_wstrb = exp_lsu ? ws : 8'h00;
      return v;
   endfunction

   // Starts just after a rising edge with the DUT in IDLE; memory ready, 1-cycle response.
   task automatic run_row(input vec_t v, input int idx);
      ifu_req_valid = v.ifu_v; lsu_req_valid = v.lsu_v; lsu_wen = v.wen;
      ifu_addr = v.ia; lsu_addr = v.la; lsu_wdata = v.wd; lsu_wstrb = v.ws;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
      @(negedge clk);
      check($sformatf("row%0d lsu_req_ready", idx), lsu_req_ready, v.exp_lsu);
      check($sformatf("row%0d ifu_req_ready", idx), ifu_req_ready, v.ifu_v & ~v.exp_lsu);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("row%0d mem_req_valid", idx), mem_req_valid, 1'b1);
      check($sformatf("row%0d mem_addr", idx), mem_addr, v.exp_addr);
      check($sformatf("row%0d mem_wen", idx), mem_wen, v.exp_wen);
      check($sformatf("row%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
      check($sformatf("row%0d mem_wstrb", idx), mem_wstrb, v.exp_wstrb);
      check($sformatf("row%0d no grant in ISSUE", idx), {ifu_req_ready, lsu_req_ready}, 2'b00);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b1; mem_rdata = v.rd; mem_rsp_err = v.er;
      @(negedge clk);
      check($sformatf("row%0d mem_rsp_ready", idx), mem_rsp_ready, 1'b1);
      check($sformatf("row%0d rsp early", idx), {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0; mem_rdata = '0; mem_rsp_err = 1'b0;
      @(negedge clk);
      check($sformatf("row%0d rsp_valid {ifu,lsu}", idx), {ifu_rsp_valid, lsu_rsp_valid},
            v.exp_lsu ? 2'b01 : 2'b10);
      check($sformatf("row%0d rdata", idx), v.exp_lsu ? lsu_rdata : ifu_rdata, v.rd);
      check($sformatf("row%0d rsp_err", idx), v.exp_lsu ? lsu_rsp_err : ifu_rsp_err, v.er);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          seen, cnt;
      logic [63:0] got;
      logic        gerr;
      logic [31:0] gaddr;

      // Row 0: lone LSU store; rows 1-12: both masters pending (expected L,L,L,L,I,L,L,L,L,I,L,L);
      // row 13: lone IFU read.
      vecs[0] = mk(1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hF0,
                   64'h0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         vecs[i+1] = mk(1'b1, 1'b1, i[0], 32'h8000_0200 + 32'(i * 4), 32'h8000_1000 + 32'(i * 8),
                        {32'hC0DE_0000 | 32'(i), 32'h5A5A_5A5A}, 8'hFF ^ 8'(i),
                        64'hA5A5_0000_0000_0000 | 64'(i), (i == 6), !(i == 4 || i == 9));
      end
      vecs[13] = mk(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 64'h0, 8'h00,
                    64'h0000_0013_0000_0297, 1'b0, 1'b0);

      rst = 1'b1;
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b0; ifu_addr = 32'h8000_0000; lsu_addr = '0;
      lsu_wen = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; mem_rsp_err = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("reset ifu_req_ready", ifu_req_ready, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset mem_req_valid", mem_req_valid, 1'b0);
      check("reset mem_rsp_ready", mem_rsp_ready, 1'b0);
      check("reset rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
      @(posedge clk); #1;
      rst = 1'b0; ifu_req_valid = 1'b0;

      for (int r = 0; r < 14; r++) run_row(vecs[r], r);

      // IFU read with 5 empty WAIT cycles: response in WAIT cycle 6, DELIVER at accept+8.
      lsu_req_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
      @(negedge clk);
      check("slow ifu_req_ready", ifu_req_ready, 1'b1);
      check("slow idle busy", busy, 1'b0);
      @(posedge clk); #1;
      ifu_req_valid = 1'b0; cnt = 0; seen = 0; got = '0; gerr = 1'b0; gaddr = '0;
      for (int k = 1; k <= 12; k++) begin
         mem_rsp_valid = (k == 7);
         mem_rdata = (k == 7) ? 64'hDEAD_BEEF_0000_0013 : 64'h0BAD_0BAD_0BAD_0BAD;
         @(negedge clk);
         if (busy) cnt++;
         if (k == 1) gaddr = mem_addr;
         if (ifu_rsp_valid && seen == 0) begin seen = k; got = ifu_rdata; gerr = ifu_rsp_err; end
         @(posedge clk); #1;
      end
      check("slow mem_addr", gaddr, 32'h8000_0000);
      check("slow rsp cycle", seen, 8);
      check("slow ifu_rdata", got, 64'hDEAD_BEEF_0000_0013);
      check("slow ifu_rsp_err", gerr, 1'b0);
      check("slow busy cycles", cnt, 8);

      // LSU load never answered: timeout after 8 cycles, then drain holds off the IFU.
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_2000; ifu_req_valid = 1'b0;
      @(negedge clk);
      check("tmo lsu_req_ready", lsu_req_ready, 1'b1);
      @(posedge clk); #1;
      lsu_req_valid = 1'b0; seen = 0; got = '1; gerr = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 10) begin ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040; end
         mem_rsp_valid = (k == 12);
         mem_rdata = (k == 12) ? 64'hBADB_ADBA_DBAD_BAD0 : 64'h0;
         @(negedge clk);
         if (lsu_rsp_valid && seen == 0) begin seen = k; got = lsu_rdata; gerr = lsu_rsp_err; end
         if (k == 9) check("tmo deliver mem_rsp_ready", mem_rsp_ready, 1'b1);
         if (k >= 10) begin
            check($sformatf("tmo drain blocks ifu k%0d", k), ifu_req_ready, 1'b0);
            check($sformatf("tmo drain mem_rsp_ready k%0d", k), mem_rsp_ready, 1'b1);
         end
         if (k == 10) check("tmo drain busy", busy, 1'b1);
         @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b0; mem_rdata = '0;
      check("tmo rsp cycle", seen, 9);
      check("tmo lsu_rdata", got, 64'h0);
      check("tmo lsu_rsp_err", gerr, 1'b1);
      @(negedge clk);
      check("tmo post-drain ifu_req_ready", ifu_req_ready, 1'b1);
      check("tmo post-drain mem_rsp_ready", mem_rsp_ready, 1'b0);
      check("tmo post-drain busy", busy, 1'b0);
      @(posedge clk); #1;
      ifu_req_valid = 1'b0;
      @(negedge clk);
      check("tmo next mem_addr", mem_addr, 32'h8000_0040);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0; mem_rdata = '0;
      @(negedge clk);
      check("tmo next ifu_rsp_valid", ifu_rsp_valid, 1'b1);
      check("tmo next ifu_rdata", ifu_rdata, 64'h1234_5678_9ABC_DEF0);
      check("tmo next ifu_rsp_err", ifu_rsp_err, 1'b0);
      @(posedge clk); #1;

      // LSU response held for 6 cycles while the IFU waits.
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_3000;
      @(negedge clk);
      check("hold lsu_req_ready", lsu_req_ready, 1'b1);
      @(posedge clk); #1;
      lsu_req_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080; lsu_rsp_ready = 1'b0;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b1; mem_rdata = 64'hCAFE_F00D_0BAD_C0DE;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0; mem_rdata = '0;
      for (int k = 3; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("hold lsu_rsp_valid k%0d", k), lsu_rsp_valid, 1'b1);
         check($sformatf("hold lsu_rdata k%0d", k), lsu_rdata, 64'hCAFE_F00D_0BAD_C0DE);
         check($sformatf("hold ifu_req_ready k%0d", k), ifu_req_ready, 1'b0);
         @(posedge clk); #1;
      end
      lsu_rsp_ready = 1'b1;
      @(negedge clk);
      check("hold release lsu_rsp_valid", lsu_rsp_valid, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("hold then ifu_req_ready", ifu_req_ready, 1'b1);
      @(posedge clk); #1;
      ifu_req_valid = 1'b0;
      @(posedge clk); #1;

      // Now in WAIT for the IFU read: reset abandons it.
      rst = 1'b1;
      @(negedge clk);
      check("rst wait mem_rsp_ready", mem_rsp_ready, 1'b0);
      check("rst wait busy", busy, 1'b0);
      check("rst wait mem_addr", mem_addr, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_4000;
      lsu_wdata = 64'h0102_0304_0506_0708; lsu_wstrb = 8'h0F;
      @(negedge clk);
      check("post-rst lsu_req_ready", lsu_req_ready, 1'b1);
      check("post-rst busy", busy, 1'b0);
      check("post-rst mem_rsp_ready", mem_rsp_ready, 1'b0);
      check("post-rst mem_addr", mem_addr, 32'h0);
      @(posedge clk); #1;
      lsu_req_valid = 1'b0;
      @(negedge clk);
      check("post-rst mem_req_valid", mem_req_valid, 1'b1);
      check("post-rst issue mem_addr", mem_addr, 32'h8000_4000);
      check("post-rst issue mem_wstrb", mem_wstrb, 8'h0F);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b1; mem_rdata = '0;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      check("post-rst lsu_rsp_valid", lsu_rsp_valid, 1'b1);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
